// File: rtl/pipelined_multiplier_fu.sv
// pipelined_multiplier_fu: STAGES-deep signed/unsigned multiplier with valid/ready flow control.
// Optional accumulate (acc port, accumulator, final-stage adder) is built when MULT_FU_ACC_EN is defined.
module pipelined_multiplier_fu #(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 3,
  parameter int OUT_WIDTH = 2 * WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 on_off,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
`ifdef MULT_FU_ACC_EN
  input  logic                 acc,
`endif
  output logic                 ack,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] c
);

  function automatic logic signed [OUT_WIDTH-1:0] op_ext(input logic [WIDTH-1:0] x,
                                                        input logic sgn);
    op_ext = sgn ? {{(OUT_WIDTH-WIDTH){x[WIDTH-1]}}, x} : {{(OUT_WIDTH-WIDTH){1'b0}}, x};
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] wrap_add(input logic signed [OUT_WIDTH-1:0] x,
                                                          input logic signed [OUT_WIDTH-1:0] y);
    wrap_add = x + y;
  endfunction

  logic                        stall;
  logic                        in_fire;
  logic                        flush;
  logic [STAGES-1:0]           vld_p;
  logic signed [OUT_WIDTH-1:0] data_p [STAGES];
  logic signed [OUT_WIDTH-1:0] op_a;
  logic signed [OUT_WIDTH-1:0] op_b;
  logic signed [OUT_WIDTH-1:0] prod;
  logic signed [OUT_WIDTH-1:0] last_in;
  logic signed [OUT_WIDTH-1:0] last_val;
  logic                        last_vld_in;

  assign stall    = vld_p[STAGES-1] && !out_ready;
  assign in_ready = on_off && !reset && !stall;
  assign in_fire  = in_valid && in_ready;
  assign flush    = reset || !on_off;

  // Operands extended to the full result width make the low OUT_WIDTH product bits exact in both modes
  assign op_a = op_ext(a, signed_mode);
  assign op_b = op_ext(b, signed_mode);
  assign prod = op_a * op_b;

  // Value entering the last stage: straight from the multiplier when there is only one stage
  generate
    if (STAGES == 1) begin : g_last_direct
      assign last_in     = prod;
      assign last_vld_in = in_fire;
    end else begin : g_last_piped
      assign last_in     = data_p[STAGES-2];
      assign last_vld_in = vld_p[STAGES-2];
    end
  endgenerate

`ifdef MULT_FU_ACC_EN
  logic signed [OUT_WIDTH-1:0] accum;
  logic                        acc_last;

  generate
    if (STAGES == 1) begin : g_acc_direct
      assign acc_last = acc;
    end else begin : g_acc_piped
      logic [STAGES-2:0] acc_p;
      always_ff @(posedge clk) begin
        if (flush) begin
          acc_p <= '0;
        end else if (!stall) begin
          acc_p[0] <= in_fire && acc;
          for (int s = 1; s <= STAGES-2; s++) acc_p[s] <= acc_p[s-1];
        end
      end
      assign acc_last = acc_p[STAGES-2];
    end
  endgenerate

  assign last_val = acc_last ? wrap_add(last_in, accum) : last_in;

  always_ff @(posedge clk) begin
    if (flush) begin
      accum <= '0;
    end else if (!stall && last_vld_in) begin
      accum <= last_val;
    end
  end
`else
  assign last_val = last_in;
`endif

  // Stage registers: bubbles carry zero data so c reads 0 whenever ack is low
  always_ff @(posedge clk) begin
    if (flush) begin
      vld_p <= '0;
      for (int s = 0; s < STAGES; s++) data_p[s] <= '0;
    end else if (!stall) begin
      vld_p[0]  <= in_fire;
      data_p[0] <= in_fire ? prod : '0;
      for (int s = 1; s < STAGES; s++) begin
        vld_p[s]  <= vld_p[s-1];
        data_p[s] <= data_p[s-1];
      end
      // Last stage takes the (possibly accumulated) value; overrides the plain shift above
      vld_p[STAGES-1]  <= last_vld_in;
      data_p[STAGES-1] <= last_vld_in ? last_val : '0;
    end
  end

  assign ack = vld_p[STAGES-1];
  assign c   = data_p[STAGES-1];

endmodule

// File: tb/tb_pipelined_multiplier_fu.sv
// Bench for pipelined_multiplier_fu (WIDTH=8, STAGES=3): table vectors, stall, reset and flush
// sequences, scoreboarded in order; the accumulate sequence is included when MULT_FU_ACC_EN is defined.
module tb_pipelined_multiplier_fu;
  localparam int WIDTH  = 8;
  localparam int STAGES = 3;
  localparam int OW     = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic             on_off;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             ack;
  logic             out_ready;
  logic [OW-1:0]    c;
`ifdef MULT_FU_ACC_EN
  logic             acc;
`endif

  int tests      = 0;
  int fails      = 0;
  int delivered  = 0;
  int stall_seen = 0;
  bit armed      = 1'b0;
  bit prev_stall = 1'b0;
  logic [OW-1:0] prev_c;
  logic [OW-1:0] sbq [$];

  always #5 clk = ~clk;

  pipelined_multiplier_fu #(.WIDTH(WIDTH), .STAGES(STAGES), .OUT_WIDTH(OW)) dut (
    .clk(clk),
    .reset(reset),
    .on_off(on_off),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .signed_mode(signed_mode),
`ifdef MULT_FU_ACC_EN
    .acc(acc),
`endif
    .ack(ack),
    .out_ready(out_ready),
    .c(c)
  );

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        sm;
    logic [15:0] exp_c;
  } vec_t;
  vec_t vecs [11];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    longint xi;
    longint yi;
    xi = s ? longint'($signed(x)) : longint'(x);
    yi = s ? longint'($signed(y)) : longint'(y);
    return 16'(xi * yi);
  endfunction

  // Output monitor: pops on transfers, checks idle zeros and stall behaviour
  always @(negedge clk) begin
    if (armed && !reset && on_off) begin
      if (ack && out_ready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: c=%0h with ack=1, expected no result (t=%0t)", c, $time);
        end else begin
          check("result", c, sbq.pop_front());
        end
        delivered++;
      end
      if (!ack) check("c_idle_zero", c, 0);
      if (prev_stall) begin
        check("stall_hold_c", c, prev_c);
        check("stall_hold_ack", ack, 1);
      end
      if (ack && !out_ready) begin
        check("in_ready_stall", in_ready, 0);
        stall_seen++;
      end
      prev_stall = ack && !out_ready;
      prev_c     = c;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vs,
                      input logic [15:0] exp_c);
    bit done;
    done        = 1'b0;
    a           = va;
    b           = vb;
    signed_mode = vs;
    in_valid    = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(exp_c);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for 40 cycles, expected acceptance");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sbq.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0;
    time  t0;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'hFF, 8'h02, 1'b1, 16'hFFFE};
    vecs[2]  = '{8'hFF, 8'h02, 1'b0, 16'h01FE};
    vecs[3]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[4]  = '{8'h80, 8'h80, 1'b0, 16'h4000};
    vecs[5]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[7]  = '{8'h00, 8'h55, 1'b1, 16'h0000};
    vecs[8]  = '{8'h01, 8'h80, 1'b1, 16'hFF80};
    vecs[9]  = '{8'h01, 8'h80, 1'b0, 16'h0080};
    vecs[10] = '{8'hAA, 8'h55, 1'b0, 16'h3872};

    reset = 1'b1; on_off = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; signed_mode = 1'b0;
`ifdef MULT_FU_ACC_EN
    acc = 1'b0;
`endif
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_ack", ack, 0);
    check("reset_c", c, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    armed = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency: result appears exactly STAGES cycles after acceptance
    send(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    in_valid = 1'b0;
    @(negedge clk); check("lat_cycle1_ack", ack, 0);
    @(negedge clk); check("lat_cycle2_ack", ack, 0);
    @(negedge clk); check("lat_cycle3_ack", ack, 1);
    check("lat_cycle3_c", c, 16'hFE01);
    drain();

    // Table vectors streamed back-to-back
    d0 = delivered;
    t0 = $time;
    for (int i = 0; i < 11; i++) send(vecs[i].va, vecs[i].vb, vecs[i].sm, vecs[i].exp_c);
    check("throughput_cycles", ($time - t0) / 10, 11);
    in_valid = 1'b0;
    drain();
    check("table_delivered", delivered - d0, 11);

    // Stall: out_ready low from cycle 2 to cycle 6 of a 5-transaction burst
    d0 = delivered;
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          logic [7:0] xa;
          logic [7:0] xb;
          xa = 8'(i * 37 + 3);
          xb = 8'(i + 9);
          send(xa, xb, 1'(i % 2), model(xa, xb, 1'(i % 2)));
        end
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_delivered", delivered - d0, 5);
    check("stall_observed", stall_seen > 0, 1);

    // Reset with three transactions in flight
    for (int i = 0; i < 3; i++) send(8'(i + 5), 8'h0C, 1'b0, model(8'(i + 5), 8'h0C, 1'b0));
    reset = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("midrst_ack", ack, 0);
    check("midrst_c", c, 0);
    repeat (6) @(posedge clk);
    #1;

    // One-cycle on_off=0 mid-stream
    for (int i = 0; i < 3; i++) send(8'(i + 20), 8'hF0, 1'b1, model(8'(i + 20), 8'hF0, 1'b1));
    on_off = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    on_off = 1'b1;
    in_valid = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("flush_ack", ack, 0);
    check("flush_c", c, 0);
    @(posedge clk);
    #1;
    d0 = delivered;
    for (int i = 0; i < 3; i++) send(8'(i + 40), 8'h81, 1'b1, model(8'(i + 40), 8'h81, 1'b1));
    in_valid = 1'b0;
    drain();
    check("flush_resume_delivered", delivered - d0, 3);

`ifdef MULT_FU_ACC_EN
    acc = 1'b0; send(8'd3, 8'd4, 1'b0, 16'd12);
    acc = 1'b1; send(8'd2, 8'd5, 1'b0, 16'd22);
    acc = 1'b1; send(8'd1, 8'd1, 1'b0, 16'd23);
    in_valid = 1'b0;
    acc = 1'b0;
    drain();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    acc = 1'b1; send(8'd1, 8'd1, 1'b0, 16'd1);
    in_valid = 1'b0;
    acc = 1'b0;
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_multiplier_fu.md
PIPELINED_MULTIPLIER_FU -- requirements
Module: pipelined_multiplier_fu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (legal values 2..64).
REQ-002 SHALL have parameter STAGES, default 3, pipeline depth in register stages (legal values 1..8).
REQ-003 SHALL have parameter OUT_WIDTH, default 2*WIDTH, result width; the only legal value is OUT_WIDTH = 2*WIDTH.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port on_off, input, 1 bit, unit enable; 0 means flush and idle.
REQ-007 SHALL have port in_valid, input, 1 bit, operands present.
REQ-008 SHALL have port in_ready, output, 1 bit, unit can accept operands.
REQ-009 SHALL have port a, input, WIDTH bits, multiplicand.
REQ-010 SHALL have port b, input, WIDTH bits, multiplier.
REQ-011 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned.
REQ-012 SHALL have port acc, input, 1 bit, accumulate request; present only under MULT_FU_ACC_EN.
REQ-013 SHALL have port ack, output, 1 bit, result valid (out_valid).
REQ-014 SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-015 SHALL have port c, output, OUT_WIDTH bits, result.

Function
REQ-016 SHALL accept a transaction on a clk edge where in_valid && in_ready; a, b, signed_mode (and acc) SHALL be captured together with the transaction.
REQ-017 SHALL define stall = ack && !out_ready and in_ready = on_off && !reset && !stall.
REQ-018 SHALL compute, per transaction, the full product over OUT_WIDTH bits: operands are sign-extended if signed_mode=1 and zero-extended otherwise.
REQ-019 SHALL hold one valid bit per stage; when not stalled, valid bits and data SHALL advance one stage per cycle, and stage 0 valid SHALL load (in_valid && in_ready).
REQ-020 SHALL, with no stall, present the result with ack=1 exactly STAGES cycles after acceptance (STAGES=1: the cycle after acceptance).
REQ-021 SHALL sustain a throughput of one transaction per cycle while out_ready=1; bubbles SHALL propagate as ack=0.
REQ-022 SHALL, during a stall, freeze all stages, keep c and ack stable, and lose or duplicate no transaction.
REQ-023 SHALL complete a result transfer on any edge where ack && out_ready.
REQ-024 SHALL, in the same cycle as a transfer, accept a new input (in_ready=1 because stall=0).
REQ-025 SHALL drive c with the last-stage data, and c SHALL be 0 whenever ack=0 after reset or flush.
REQ-026 SHALL, when on_off=0, clear all stage valids and data to 0 on the next edge; in-flight results are discarded and no transaction is accepted.

Reset
REQ-027 SHALL, on reset=1 at a clk edge, clear every stage valid bit and data register, giving ack=0 and c=0 on the following cycle.
REQ-028 SHALL drive in_ready=0 while reset=1.
REQ-029 SHALL give reset mid-operation priority over on_off, in_valid and out_ready, with all in-flight transactions dropped.
REQ-030 SHALL clear the accumulator to 0 on reset (under MULT_FU_ACC_EN).

Configuration
REQ-031 SHALL support macro MULT_FU_ACC_EN; when defined, the port acc, an OUT_WIDTH accumulator register, and the adder in the final stage SHALL exist.
REQ-032 SHALL, under MULT_FU_ACC_EN, when a transaction enters the last stage, set its result to product + accumulator if acc=1 and to product if acc=0, modulo 2^OUT_WIDTH, and load the accumulator with that result.
REQ-033 SHALL, under MULT_FU_ACC_EN, hold the accumulator during stalls and clear it on on_off=0.
REQ-034 SHALL, without MULT_FU_ACC_EN, omit the acc port and accumulator, so that c is always the plain product.

Verification
REQ-035 SHALL cover: WIDTH=8, STAGES=3, unsigned, a=0xFF, b=0xFF, out_ready=1 -> ack=1 with c=0xFE01 three cycles after acceptance.
REQ-036 SHALL cover: signed_mode=1, a=0xFF (-1), b=0x02 -> c=0xFFFE; signed_mode=0 with the same operands -> c=0x01FE.
REQ-037 SHALL cover: 5 back-to-back inputs with out_ready=0 from cycle 2 to cycle 6 -> in_ready=0 while ack=1, all 5 results delivered in order, none duplicated.
REQ-038 SHALL cover: reset pulse with 3 transactions in flight -> ack=0 and c=0 the next cycle, and no stale result is ever output.
REQ-039 SHALL cover: with MULT_FU_ACC_EN, sequence (3*4, acc=0), (2*5, acc=1), (1*1, acc=1) -> c = 12, 22, 23.
REQ-040 SHALL cover: on_off=0 for one cycle mid-stream -> pipeline empties, in_ready=0 during that cycle, and normal flow resumes when on_off=1.
